// File: rtl/pu_spi_ping_pong.sv
// rtl/pu_spi_ping_pong.sv - ping-pong word buffer between a processing unit and an SPI mode-0 slave
// One bank faces the PU while the other faces SPI; signal_cycle swaps them outside SPI frames.
module pu_spi_ping_pong #(
   parameter int DATA_WIDTH  = 32,
   parameter int ATTR_WIDTH  = 4,
   parameter int BUF_SIZE    = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signal_cycle,
   input  logic                  signal_wr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ATTR_WIDTH-1:0] attr_in,
   input  logic                  signal_oe,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ATTR_WIDTH-1:0] attr_out,
   output logic                  flag_start,
   output logic                  flag_stop,
   input  logic                  mosi,
   output logic                  miso,
   input  logic                  sclk,
   input  logic                  cs
);
   localparam int PTR_W = $clog2(BUF_SIZE + 1);
   localparam int BIT_W = $clog2(DATA_WIDTH);
   localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(BUF_SIZE);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, sync_fill;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_q, cs_q, cs_armed;
   logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

   logic [DATA_WIDTH-1:0]  tx_mem [0:1][0:BUF_SIZE-1];
   logic [DATA_WIDTH-1:0]  rx_mem [0:1][0:BUF_SIZE-1];
   logic                   bank_sel;
   logic                   pu_bank;

   logic                   in_frame, overrun, spi_full, word_done;
   logic [PTR_W-1:0]       spi_ptr, load_idx, rx_count_spi, tx_count_spi;
   logic [BIT_W-1:0]       bit_cnt;
   logic [DATA_WIDTH-1:0]  tx_shift, load_word, rx_word;
   logic [DATA_WIDTH-2:0]  rx_shift;

   logic [PTR_W-1:0]       wr_ptr, rd_ptr, rx_count_pu, rx_count_new;
   logic                   swap_pending, swap_now, wr_ok, rd_ok;

   logic                   unused_attr;
   assign unused_attr = ^attr_in;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];

   // cs_armed blocks a frame from starting if cs was already low when reset released
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         sync_fill <= '0;
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
         cs_armed  <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
         sclk_q    <= sclk_s;
         cs_q      <= cs_s;
         if (sync_fill[SYNC_STAGES-1] && cs_s)
            cs_armed <= 1'b1;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_q;
   assign sclk_fall = ~sclk_s & sclk_q;
   assign cs_fall   = cs_q & ~cs_s & cs_armed;
   assign cs_rise   = ~cs_q & cs_s & in_frame;

   assign pu_bank   = ~bank_sel;
   assign spi_full  = (spi_ptr == PTR_MAX);
   assign word_done = in_frame & sclk_rise & ~spi_full & (bit_cnt == BIT_LAST);
   assign rx_word   = {rx_shift, mosi_s};
   assign load_idx  = cs_fall ? '0 : spi_ptr + PTR_W'(1);

   // Slots at or beyond the published TX count go out as zero
   always_comb begin
      load_word = '0;
      if (load_idx < tx_count_spi)
         load_word = tx_mem[bank_sel][load_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_frame     <= 1'b0;
         spi_ptr      <= '0;
         bit_cnt      <= '0;
         tx_shift     <= '0;
         rx_shift     <= '0;
         overrun      <= 1'b0;
         rx_count_spi <= '0;
         flag_stop    <= 1'b0;
      end else begin
         flag_stop <= cs_rise;
         if (cs_fall) begin
            in_frame <= 1'b1;
            spi_ptr  <= '0;
            bit_cnt  <= '0;
            tx_shift <= load_word;
            overrun  <= 1'b0;
         end else if (cs_rise) begin
            in_frame     <= 1'b0;
            rx_count_spi <= spi_ptr;
            bit_cnt      <= '0;
         end else if (in_frame) begin
            if (sclk_rise) begin
               if (spi_full) begin
                  overrun <= 1'b1;
               end else begin
                  rx_shift <= rx_word[DATA_WIDTH-2:0];
                  if (bit_cnt == BIT_LAST) begin
                     spi_ptr  <= spi_ptr + PTR_W'(1);
                     tx_shift <= load_word;
                     bit_cnt  <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end
            end else if (sclk_fall && bit_cnt != '0) begin
               // the fall right after a word load must keep the fresh MSB on miso
               tx_shift <= tx_shift << 1;
            end
         end
      end
   end

   assign miso = in_frame & ~spi_full & ~overrun & tx_shift[DATA_WIDTH-1];

   assign swap_now     = cs_s & (signal_cycle | swap_pending);
   assign wr_ok        = signal_wr & (wr_ptr < PTR_MAX);
   assign rd_ok        = signal_oe & (rd_ptr < rx_count_pu);
   assign rx_count_new = cs_rise ? spi_ptr : rx_count_spi;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_sel     <= 1'b0;
         tx_count_spi <= '0;
         rx_count_pu  <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         swap_pending <= 1'b0;
         flag_start   <= 1'b0;
      end else begin
         flag_start <= swap_now;
         if (swap_now) begin
            bank_sel     <= ~bank_sel;
            tx_count_spi <= wr_ptr;
            rx_count_pu  <= rx_count_new;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            swap_pending <= 1'b0;
         end else begin
            if (signal_cycle && !cs_s)
               swap_pending <= 1'b1;
            if (wr_ok)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok)
               rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // A write coinciding with a swap still lands in the outgoing PU bank
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < BUF_SIZE; i++)
               tx_mem[b][i] <= '0;
      end else if (wr_ok) begin
         tx_mem[pu_bank][wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < BUF_SIZE; i++)
               rx_mem[b][i] <= '0;
      end else if (word_done) begin
         rx_mem[bank_sel][spi_ptr] <= rx_word;
      end
   end

   always_comb begin
      data_out = '0;
      attr_out = '0;
      if (!rst && signal_oe) begin
         if (rd_ok)
            data_out = rx_mem[pu_bank][rd_ptr];
         else
            attr_out = ATTR_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_pu_spi_ping_pong.sv
// tb/tb_pu_spi_ping_pong.sv - randomized self-checking bench for pu_spi_ping_pong
// Queue-based model: PU writes, SPI-facing TX words, last received frame, PU-readable words.
module tb_pu_spi_ping_pong;
   localparam int DW   = 32;
   localparam int AW   = 4;
   localparam int BS   = 6;
   localparam int HALF = 6;

   logic          clk = 1'b0;
   logic          rst, signal_cycle, signal_wr, signal_oe, mosi, sclk, cs;
   logic [DW-1:0] data_in;
   logic [AW-1:0] attr_in;
   logic [DW-1:0] data_out;
   logic [AW-1:0] attr_out;
   logic          flag_start, flag_stop, miso;

   pu_spi_ping_pong #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .BUF_SIZE(BS), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .signal_cycle(signal_cycle), .signal_wr(signal_wr),
      .data_in(data_in), .attr_in(attr_in), .signal_oe(signal_oe), .data_out(data_out),
      .attr_out(attr_out), .flag_start(flag_start), .flag_stop(flag_stop),
      .mosi(mosi), .miso(miso), .sclk(sclk), .cs(cs)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int fs_cnt = 0;
   int fp_cnt = 0;
   int both_cnt = 0;
   int fs_at_rise;

   always @(negedge clk) begin
      if (flag_start) fs_cnt++;
      if (flag_stop) fp_cnt++;
      if (flag_start && flag_stop) both_cnt++;
   end

   logic [DW-1:0] m_pu_wr[$];
   logic [DW-1:0] m_spi_tx[$];
   logic [DW-1:0] m_last_rx[$];
   logic [DW-1:0] m_pu_rx[$];
   logic [DW-1:0] tx_buf [0:7];
   logic [DW-1:0] rx_got [0:7];

   function automatic void model_clear();
      m_pu_wr.delete(); m_spi_tx.delete(); m_last_rx.delete(); m_pu_rx.delete();
   endfunction

   function automatic void model_write(input logic [DW-1:0] w);
      if (m_pu_wr.size() < BS) m_pu_wr.push_back(w);
   endfunction

   function automatic void model_swap();
      m_spi_tx = m_pu_wr;
      m_pu_rx  = m_last_rx;
      m_pu_wr.delete();
   endfunction

   function automatic void model_frame(input int nbits);
      int n;
      n = nbits / DW;
      if (n > BS) n = BS;
      m_last_rx.delete();
      for (int i = 0; i < n; i++) m_last_rx.push_back(tx_buf[i]);
   endfunction

   function automatic logic [DW-1:0] model_miso_word(input int i);
      return (i < m_spi_tx.size()) ? m_spi_tx[i] : '0;
   endfunction

   function automatic void model_read(output logic [DW-1:0] d, output logic [AW-1:0] a);
      if (m_pu_rx.size() > 0) begin d = m_pu_rx.pop_front(); a = '0; end
      else begin d = '0; a = 4'd1; end
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; signal_cycle = 0; signal_wr = 0; signal_oe = 0;
      mosi = 0; sclk = 0; cs = 1; data_in = '0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (4) tick();
      model_clear();
   endtask

   task automatic pu_write(input logic [DW-1:0] w);
      signal_wr = 1'b1; data_in = w; attr_in = AW'($urandom());
      tick();
      signal_wr = 1'b0;
      model_write(w);
   endtask

   task automatic pu_cycle();
      signal_cycle = 1'b1;
      tick();
      signal_cycle = 1'b0;
      tick();
   endtask

   task automatic pu_read(output logic [DW-1:0] d, output logic [AW-1:0] a);
      signal_oe = 1'b1;
      #1;
      d = data_out; a = attr_out;
      tick();
      signal_oe = 1'b0;
   endtask

   task automatic spi_frame(input int nbits, input int cyc_a, input int cyc_b);
      int w, k;
      for (int i = 0; i < 8; i++) rx_got[i] = '0;
      cs = 1'b0;
      repeat (8) tick();
      for (int b = 0; b < nbits; b++) begin
         w = b / DW; k = DW - 1 - (b % DW);
         mosi = tx_buf[w][k];
         if (b == cyc_a || b == cyc_b) begin
            signal_cycle = 1'b1; tick(); signal_cycle = 1'b0;
            repeat (HALF - 1) tick();
         end else begin
            repeat (HALF) tick();
         end
         rx_got[w][k] = miso;
         sclk = 1'b1;
         repeat (HALF) tick();
         sclk = 1'b0;
      end
      repeat (HALF) tick();
      fs_at_rise = fs_cnt;
      cs = 1'b1; mosi = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; signal_cycle = 0; signal_wr = 0; signal_oe = 1;
      mosi = 0; sclk = 0; cs = 1; data_in = '0; attr_in = '0;
      repeat (2) tick();
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rst_miso got %b exp 0", miso); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_data_out got %h exp 0", data_out); end
      checks++; if (attr_out !== '0) begin errors++; $display("FAIL rst_attr_out got %h exp 0", attr_out); end
      checks++; if (flag_start !== 1'b0) begin errors++; $display("FAIL rst_flag_start got %b exp 0", flag_start); end
      checks++; if (flag_stop !== 1'b0) begin errors++; $display("FAIL rst_flag_stop got %b exp 0", flag_stop); end
      rst = 1'b0;
      repeat (3) tick();
      #1;
      checks++; if (attr_out[0] !== 1'b1 || data_out !== '0) begin errors++; $display("FAIL empty_read got data %h attr %h exp data 0 attr[0] 1", data_out, attr_out); end
      tick();
      signal_oe = 1'b0;
      #1;
      checks++; if (attr_out !== '0) begin errors++; $display("FAIL idle_attr got %h exp 0", attr_out); end
      tick();
   endtask

   task automatic test_tx_path();
      int fs0, n;
      do_reset();
      fs0 = fs_cnt;
      pu_write(32'hA1B2C3D4);
      pu_write(32'h01020304);
      pu_cycle(); model_swap();
      checks++; if (fs_cnt - fs0 !== 1) begin errors++; $display("FAIL tx_flag_start_count got %0d exp 1", fs_cnt - fs0); end
      for (int i = 0; i < 8; i++) tx_buf[i] = $urandom();
      spi_frame(64, -1, -1); model_frame(64);
      checks++; if (rx_got[0] !== 32'hA1B2C3D4) begin errors++; $display("FAIL tx_word0 got %h exp a1b2c3d4", rx_got[0]); end
      checks++; if (rx_got[1] !== model_miso_word(1)) begin errors++; $display("FAIL tx_word1 got %h exp %h", rx_got[1], model_miso_word(1)); end
      for (int it = 0; it < 3; it++) begin
         n = $urandom_range(1, BS);
         for (int i = 0; i < n; i++) pu_write($urandom());
         pu_cycle(); model_swap();
         for (int i = 0; i < 8; i++) tx_buf[i] = $urandom();
         spi_frame(DW * (n + 1), -1, -1); model_frame(DW * (n + 1));
         for (int i = 0; i <= n; i++) begin
            checks++;
            if (rx_got[i] !== model_miso_word(i)) begin errors++; $display("FAIL tx_rand[%0d][%0d] got %h exp %h", it, i, rx_got[i], model_miso_word(i)); end
         end
      end
   endtask

   task automatic test_rx_path();
      logic [DW-1:0] d, ed;
      logic [AW-1:0] a, ea;
      int k;
      do_reset();
      tx_buf[0] = 32'hDEADBEEF;
      spi_frame(DW, -1, -1); model_frame(DW);
      pu_cycle(); model_swap();
      pu_read(d, a);
      checks++; if (d !== 32'hDEADBEEF || a !== '0) begin errors++; $display("FAIL rx_first got %h/%h exp deadbeef/0", d, a); end
      pu_read(d, a);
      checks++; if (d !== '0 || a[0] !== 1'b1) begin errors++; $display("FAIL rx_second got %h/%h exp 0/attr0=1", d, a); end
      for (int it = 0; it < 2; it++) begin
         k = $urandom_range(1, BS);
         for (int i = 0; i < 8; i++) tx_buf[i] = $urandom();
         spi_frame(DW * k, -1, -1); model_frame(DW * k);
         pu_cycle(); model_swap();
         for (int i = 0; i <= k; i++) begin
            pu_read(d, a); model_read(ed, ea);
            checks++;
            if (d !== ed || (ea[0] ? a[0] !== 1'b1 : a !== '0)) begin errors++; $display("FAIL rx_rand[%0d][%0d] got %h/%h exp %h/%h", it, i, d, a, ed, ea); end
         end
      end
   endtask

   task automatic test_overrun();
      logic [DW-1:0] d, ed;
      logic [AW-1:0] a, ea;
      do_reset();
      for (int i = 0; i < BS; i++) pu_write($urandom() | 32'h8000_0001);
      pu_cycle(); model_swap();
      for (int i = 0; i < 8; i++) tx_buf[i] = $urandom();
      spi_frame(DW * 7, -1, -1); model_frame(DW * 7);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (rx_got[i] !== model_miso_word(i)) begin errors++; $display("FAIL ovr_miso[%0d] got %h exp %h", i, rx_got[i], model_miso_word(i)); end
      end
      pu_cycle(); model_swap();
      for (int i = 0; i < 7; i++) begin
         pu_read(d, a); model_read(ed, ea);
         checks++;
         if (d !== ed || (ea[0] ? a[0] !== 1'b1 : a !== '0)) begin errors++; $display("FAIL ovr_read[%0d] got %h/%h exp %h/%h", i, d, a, ed, ea); end
      end
      for (int i = 0; i < 8; i++) tx_buf[i] = $urandom();
      spi_frame(DW + 20, -1, -1); model_frame(DW + 20);
      pu_cycle(); model_swap();
      for (int i = 0; i < 2; i++) begin
         pu_read(d, a); model_read(ed, ea);
         checks++;
         if (d !== ed || (ea[0] ? a[0] !== 1'b1 : a !== '0)) begin errors++; $display("FAIL partial52[%0d] got %h/%h exp %h/%h", i, d, a, ed, ea); end
      end
      spi_frame(20, -1, -1); model_frame(20);
      pu_cycle(); model_swap();
      pu_read(d, a); model_read(ed, ea);
      checks++;
      if (d !== ed || a[0] !== ea[0]) begin errors++; $display("FAIL partial20 got %h/%h exp %h/%h", d, a, ed, ea); end
   endtask

   task automatic test_pending();
      logic [DW-1:0] d, ed;
      logic [AW-1:0] a, ea;
      int fs0, both0, fp0;
      do_reset();
      pu_write($urandom()); pu_write($urandom());
      pu_cycle(); model_swap();
      for (int i = 0; i < 3; i++) pu_write($urandom());
      for (int i = 0; i < 8; i++) tx_buf[i] = $urandom();
      fs0 = fs_cnt; both0 = both_cnt; fp0 = fp_cnt;
      spi_frame(2 * DW, 10, 40); model_frame(2 * DW);
      checks++; if (rx_got[0] !== model_miso_word(0) || rx_got[1] !== model_miso_word(1)) begin errors++; $display("FAIL pend_miso got %h %h exp %h %h", rx_got[0], rx_got[1], model_miso_word(0), model_miso_word(1)); end
      model_swap();
      checks++; if (fs_at_rise - fs0 !== 0) begin errors++; $display("FAIL pend_early_swap got %0d exp 0", fs_at_rise - fs0); end
      checks++; if (fs_cnt - fs0 !== 1) begin errors++; $display("FAIL pend_swap_count got %0d exp 1", fs_cnt - fs0); end
      checks++; if (both_cnt - both0 !== 1) begin errors++; $display("FAIL pend_coincident got %0d exp 1", both_cnt - both0); end
      checks++; if (fp_cnt - fp0 !== 1) begin errors++; $display("FAIL pend_stop_count got %0d exp 1", fp_cnt - fp0); end
      for (int i = 0; i < 3; i++) begin
         pu_read(d, a); model_read(ed, ea);
         checks++;
         if (d !== ed || (ea[0] ? a[0] !== 1'b1 : a !== '0)) begin errors++; $display("FAIL pend_read[%0d] got %h/%h exp %h/%h", i, d, a, ed, ea); end
      end
      spi_frame(3 * DW, -1, -1); model_frame(3 * DW);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rx_got[i] !== model_miso_word(i)) begin errors++; $display("FAIL pend_tx[%0d] got %h exp %h", i, rx_got[i], model_miso_word(i)); end
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d, ed;
      logic [AW-1:0] a, ea;
      do_reset();
      for (int i = 0; i < 7; i++) pu_write($urandom());
      pu_cycle(); model_swap();
      spi_frame(7 * DW, -1, -1); model_frame(7 * DW);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (rx_got[i] !== model_miso_word(i)) begin errors++; $display("FAIL wr_over[%0d] got %h exp %h", i, rx_got[i], model_miso_word(i)); end
      end
      pu_write($urandom());
      signal_wr = 1'b1; data_in = $urandom(); signal_cycle = 1'b1;
      tick();
      signal_wr = 1'b0; signal_cycle = 1'b0;
      tick();
      model_swap();
      spi_frame(2 * DW, -1, -1); model_frame(2 * DW);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rx_got[i] !== model_miso_word(i)) begin errors++; $display("FAIL wr_swap[%0d] got %h exp %h", i, rx_got[i], model_miso_word(i)); end
      end
      pu_write($urandom());
      pu_cycle(); model_swap();
      spi_frame(DW, -1, -1);
      checks++; if (rx_got[0] !== model_miso_word(0)) begin errors++; $display("FAIL wr_ptr_zero got %h exp %h", rx_got[0], model_miso_word(0)); end
      for (int i = 0; i < 8; i++) tx_buf[i] = $urandom();
      spi_frame(2 * DW, -1, -1); model_frame(2 * DW);
      pu_cycle(); model_swap();
      tx_buf[0] = $urandom();
      spi_frame(DW, -1, -1); model_frame(DW);
      signal_oe = 1'b1; signal_cycle = 1'b1;
      #1;
      d = data_out; a = attr_out;
      tick();
      signal_oe = 1'b0; signal_cycle = 1'b0;
      tick();
      model_read(ed, ea);
      checks++; if (d !== ed || a !== ea) begin errors++; $display("FAIL rd_swap got %h/%h exp %h/%h", d, a, ed, ea); end
      model_swap();
      for (int i = 0; i < 2; i++) begin
         pu_read(d, a); model_read(ed, ea);
         checks++;
         if (d !== ed || (ea[0] ? a[0] !== 1'b1 : a !== '0)) begin errors++; $display("FAIL rd_ptr_zero[%0d] got %h/%h exp %h/%h", i, d, a, ed, ea); end
      end
   endtask

   task automatic test_reset_midframe();
      logic [DW-1:0] d, ed;
      logic [AW-1:0] a, ea;
      logic          miso_seen;
      do_reset();
      pu_write(32'hFFFF_FFFF);
      pu_cycle();
      tx_buf[0] = $urandom();
      cs = 1'b0;
      repeat (8) tick();
      for (int b = 0; b < 16; b++) begin
         mosi = tx_buf[0][DW - 1 - b];
         repeat (HALF) tick();
         sclk = 1'b1;
         repeat (HALF) tick();
         sclk = 1'b0;
      end
      repeat (2) tick();
      rst = 1'b1; signal_oe = 1'b1;
      tick();
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL mid_rst_miso got %b exp 0", miso); end
      checks++; if (data_out !== '0 || attr_out !== '0) begin errors++; $display("FAIL mid_rst_pu got %h/%h exp 0/0", data_out, attr_out); end
      checks++; if (flag_start !== 1'b0 || flag_stop !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got %b%b exp 00", flag_start, flag_stop); end
      rst = 1'b0; signal_oe = 1'b0;
      model_clear();
      miso_seen = 1'b0;
      for (int b = 0; b < 8; b++) begin
         repeat (HALF) tick();
         miso_seen |= miso;
         sclk = 1'b1;
         repeat (HALF) tick();
         miso_seen |= miso;
         sclk = 1'b0;
      end
      checks++; if (miso_seen !== 1'b0) begin errors++; $display("FAIL post_rst_miso got %b exp 0", miso_seen); end
      cs = 1'b1; mosi = 1'b0;
      repeat (8) tick();
      tx_buf[0] = $urandom();
      spi_frame(DW, -1, -1); model_frame(DW);
      pu_cycle(); model_swap();
      for (int i = 0; i < 2; i++) begin
         pu_read(d, a); model_read(ed, ea);
         checks++;
         if (d !== ed || (ea[0] ? a[0] !== 1'b1 : a !== '0)) begin errors++; $display("FAIL post_rst_read[%0d] got %h/%h exp %h/%h", i, d, a, ed, ea); end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      attr_in = '0;
      test_reset();
      test_tx_path();
      test_rx_path();
      test_overrun();
      test_pending();
      test_back_to_back();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pu_spi_ping_pong.md
PU_SPI_PING_PONG -- requirements
Module: pu_spi_ping_pong

Interface
REQ-001 The block SHALL use the parameter DATA_WIDTH, default 32, as the word width on both the processing unit (PU) side and the SPI side.
REQ-002 The block SHALL use the parameter ATTR_WIDTH, default 4, as the attribute width; bit 0 is INVALID.
REQ-003 The block SHALL use the parameter BUF_SIZE, default 6, as the number of words per bank per direction.
REQ-004 The block SHALL use the parameter SYNC_STAGES, default 2, as the number of synchronizer flops on sclk, mosi and cs.
REQ-005 The block SHALL have ports, listed as name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, reset; asynchronous, active-high.
- signal_cycle, in, 1, computation-cycle boundary pulse.
- signal_wr, in, 1, PU write strobe.
- data_in, in, DATA_WIDTH, PU write data.
- attr_in, in, ATTR_WIDTH, ignored.
- signal_oe, in, 1, PU read strobe.
- data_out, out, DATA_WIDTH, PU read data.
- attr_out, out, ATTR_WIDTH, PU read attributes.
- flag_start, out, 1, bank-swap pulse.
- flag_stop, out, 1, SPI transaction-end pulse.
- mosi, in, 1, SPI data from master.
- miso, out, 1, SPI data to master.
- sclk, in, 1, SPI clock, mode 0.
- cs, in, 1, SPI chip select, active-low.

Function
REQ-006 The block SHALL hold two banks (bank 0, bank 1), each containing a TX array and an RX array of BUF_SIZE x DATA_WIDTH; one bank is PU-side and the other SPI-side, selected by a 1-bit register bank_sel.
REQ-007 The block SHALL pass sclk, mosi and cs through SYNC_STAGES flops and SHALL derive edges only from the synchronized signals.
REQ-008 On a synchronized cs falling edge, the block SHALL clear spi_ptr and bit_cnt, load the TX shifter with SPI-side TX[0], and clear the overrun flag.
REQ-009 While cs is low:
- on an sclk rising edge, the block SHALL shift mosi into the RX shifter, MSB first;
- on an sclk falling edge, the block SHALL shift the TX shifter left;
- miso SHALL equal the TX shifter MSB.
REQ-010 When cs is high, miso SHALL be 0.
REQ-011 On the DATA_WIDTH-th sampled bit, the block SHALL:
- write the RX shifter to SPI-side RX[spi_ptr];
- increment spi_ptr;
- load the TX shifter with SPI-side TX[spi_ptr+1], or zero if spi_ptr+1 >= tx_count_spi;
- reset bit_cnt.
REQ-012 SPI-side TX words at index >= tx_count_spi SHALL be transmitted as all-zero.
REQ-013 When spi_ptr = BUF_SIZE, further bits SHALL be discarded, miso SHALL be 0, spi_ptr SHALL saturate, and the overrun flag SHALL be set.
REQ-014 On a synchronized cs rising edge, the block SHALL latch rx_count_spi := spi_ptr, discard any partial word, and pulse flag_stop for one clk cycle.
REQ-015 On signal_wr with wr_ptr < BUF_SIZE, the block SHALL write data_in to PU-side TX[wr_ptr] and increment wr_ptr; when wr_ptr = BUF_SIZE, the write SHALL be ignored.
REQ-016 On signal_oe with rd_ptr < rx_count_pu, data_out SHALL be PU-side RX[rd_ptr] and attr_out SHALL be 0, both combinationally in the same cycle; rd_ptr SHALL increment at the clock edge.
REQ-017 On signal_oe with rd_ptr >= rx_count_pu, data_out SHALL be 0 and attr_out[0] SHALL be 1, and rd_ptr SHALL NOT change.
REQ-018 When signal_oe is low, data_out and attr_out SHALL be 0.
REQ-019 On signal_cycle with synchronized cs high, the block SHALL perform a swap in that same cycle:
- toggle bank_sel;
- tx_count_spi := wr_ptr;
- rx_count_pu := rx_count_spi;
- wr_ptr := 0 and rd_ptr := 0;
- pulse flag_start for one cycle.
REQ-020 On signal_cycle with synchronized cs low, the block SHALL set swap_pending; the swap SHALL then occur in the cycle of the cs rising edge, after rx_count_spi is latched, with flag_start and flag_stop both pulsing in that cycle.
REQ-021 If signal_wr and a swap coincide in the same cycle, the write SHALL target the pre-swap PU-side bank and SHALL NOT be counted; wr_ptr SHALL be 0 after that edge.
REQ-022 If signal_oe and a swap coincide in the same cycle, the read SHALL use the pre-swap bank and rd_ptr SHALL be 0 after that edge.
REQ-023 A second signal_cycle while swap_pending is set SHALL NOT queue an additional swap.

Reset
REQ-024 rst SHALL asynchronously clear bank_sel, all pointers and counts, swap_pending, overrun, both shifters, all bank contents and the synchronizers (cs synchronizer to 1).
REQ-025 During and after rst, outputs SHALL be: miso=0, data_out=0, attr_out=0, flag_start=0, flag_stop=0.
REQ-026 rst asserted mid-transaction SHALL abort the transaction; the next transaction SHALL begin only at a fresh cs falling edge.

Verification
REQ-027 Write 32'hA1B2C3D4 and 32'h01020304, then signal_cycle with cs high, then an SPI read of 64 bits -> miso returns A1B2C3D4 then 01020304, and flag_start pulses once.
REQ-028 Master sends 32'hDEADBEEF with cs low then high, then signal_cycle, then 2x signal_oe -> first read gives data_out=DEADBEEF, attr_out=0; second gives data_out=0, attr_out[0]=1.
REQ-029 Master clocks 7 words with BUF_SIZE=6 -> rx_count=6, 7th word discarded and miso=0 during it; a 20-bit partial frame yields rx_count equal to the complete words only.
REQ-030 signal_cycle while cs is low -> no swap until cs rises; at the cs rising edge flag_start and flag_stop pulse in the same cycle; a second signal_cycle in between causes only one swap.
REQ-031 7 signal_wr before a swap -> only 6 words transmitted; unwritten slots read as 0; rst mid-frame -> all outputs 0 and the next frame is received correctly.
